// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential advance, execute-stage redirects,
// trap entry, misaligned-target fault hold and a single boot cycle after reset.
module pc_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               IALIGN   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] link_addr,
    output logic            flush,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(IALIGN);

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] bad_addr_next;
    logic            flush_next, misaligned_next;

    logic [XLEN-1:0] jalr_sum, rel_target, target, trap_pc;
    logic            redirect_req, target_misaligned;

    assign jalr_sum   = rs1 + imm;
    assign rel_target = ex_pc + imm;
    // JALR always drops bit 0, so under IALIGN=2 it can never be misaligned.
    assign target     = (pc_src == 2'b00) ? {jalr_sum[XLEN-1:1], 1'b0} : rel_target;

    assign redirect_req      = ex_valid && (pc_src != 2'b11) &&
                               ((pc_src != 2'b10) || branch_taken);
    assign target_misaligned = |(target & ALIGN_MASK);
    assign trap_pc           = trap_vector & ~ALIGN_MASK;

    assign fetch_valid = (state == RUN);
    assign fetch_pc    = pc;
    assign link_addr   = ex_pc + XLEN'(4);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        flush_next      = 1'b0;
        misaligned_next = 1'b0;
        bad_addr_next   = bad_addr;
        if (trap_valid) begin
            pc_next    = trap_pc;
            state_next = RUN;
            flush_next = 1'b1;
        end else begin
            case (state)
                BOOT: state_next = RUN;
                RUN: begin
                    if (redirect_req && !target_misaligned) begin
                        pc_next    = target;
                        flush_next = 1'b1;
                    end else if (redirect_req) begin
                        state_next      = FAULT;
                        misaligned_next = 1'b1;
                        bad_addr_next   = target;
                        flush_next      = 1'b1;
                    end else if (fetch_ready) begin
                        pc_next = pc + PC_STEP;
                    end
                end
                FAULT: state_next = FAULT;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            flush      <= flush_next;
            misaligned <= misaligned_next;
            bad_addr   <= bad_addr_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed
// post-edge outputs, a monitor pops and compares them one cycle later.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] link_addr;
    logic        flush;
    logic        misaligned;
    logic [31:0] bad_addr;

    logic        fetch_valid2;
    logic [31:0] fetch_pc2;
    logic [31:0] link_addr2;
    logic        flush2;
    logic        misaligned2;
    logic [31:0] bad_addr2;

    int tests_run = 0;
    int tests_failed = 0;
    int step_id = 0;

    typedef struct {
        int          id;
        logic        fv;
        logic [31:0] pc;
        logic        fl;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] link;
        logic        chk2;
        logic [31:0] pc2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .IALIGN(4)) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .pc_src(pc_src), .branch_taken(branch_taken), .rs1(rs1),
        .imm(imm), .trap_valid(trap_valid), .trap_vector(trap_vector),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .link_addr(link_addr),
        .flush(flush), .misaligned(misaligned), .bad_addr(bad_addr)
    );

    // Compressed-alignment instance, free-running sequential fetch only.
    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .fetch_ready(1'b1), .ex_valid(1'b0),
        .ex_pc(32'h0), .pc_src(2'b11), .branch_taken(1'b0), .rs1(32'h0),
        .imm(32'h0), .trap_valid(1'b0), .trap_vector(32'h0),
        .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2), .link_addr(link_addr2),
        .flush(flush2), .misaligned(misaligned2), .bad_addr(bad_addr2)
    );

    task automatic cmp(input string what, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL step%0d %s: got 0x%08h expected 0x%08h", id, what, got, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("fetch_valid", e.id, {31'b0, fetch_valid}, {31'b0, e.fv});
        cmp("fetch_pc",    e.id, fetch_pc, e.pc);
        cmp("flush",       e.id, {31'b0, flush}, {31'b0, e.fl});
        cmp("misaligned",  e.id, {31'b0, misaligned}, {31'b0, e.mis});
        cmp("bad_addr",    e.id, bad_addr, e.bad);
        cmp("link_addr",   e.id, link_addr, e.link);
        if (e.chk2) cmp("fetch_pc_ialign2", e.id, fetch_pc2, e.pc2);
    endtask

    // Inputs are already driven; record what must appear after the next edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic fl,
                                 input logic mis, input logic [31:0] bad,
                                 input logic chk2, input logic [31:0] pc2);
        exp_t e;
        step_id++;
        e.id = step_id; e.fv = fv; e.pc = pc; e.fl = fl; e.mis = mis; e.bad = bad;
        e.link = ex_pc + 32'd4; e.chk2 = chk2; e.pc2 = pc2;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; fetch_ready = 1'b1; ex_valid = 1'b0; ex_pc = 32'h0;
        pc_src = 2'b11; branch_taken = 1'b0; rs1 = 32'h0; imm = 32'h0;
        trap_valid = 1'b0; trap_vector = 32'h0;

        // Reset for two cycles, then one boot cycle and sequential fetch.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);

        // Trap to 0x100, then JAL during stall.
        trap_valid = 1'b1; trap_vector = 32'h100;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        trap_valid = 1'b0; fetch_ready = 1'b0;
        ex_valid = 1'b1; pc_src = 2'b01; ex_pc = 32'h0F8; imm = 32'h40;
        applyStimulus(1'b1, 32'h138, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        ex_valid = 1'b0; pc_src = 2'b11;
        applyStimulus(1'b1, 32'h138, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h138, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // JALR bit-0 clear, then misaligned JALR target enters FAULT.
        fetch_ready = 1'b1; ex_valid = 1'b1; pc_src = 2'b00; rs1 = 32'h2001; imm = 32'h4;
        applyStimulus(1'b1, 32'h2004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        rs1 = 32'h2002; imm = 32'h0;
        applyStimulus(1'b0, 32'h2004, 1'b1, 1'b1, 32'h2002, 1'b0, 32'h0);
        ex_valid = 1'b0; pc_src = 2'b11;
        applyStimulus(1'b0, 32'h2004, 1'b0, 1'b0, 32'h2002, 1'b0, 32'h0);
        ex_valid = 1'b1; pc_src = 2'b01; ex_pc = 32'h300; imm = 32'h0;
        applyStimulus(1'b0, 32'h2004, 1'b0, 1'b0, 32'h2002, 1'b0, 32'h0);

        // Trap leaves FAULT with low bits of the vector cleared.
        ex_valid = 1'b0; pc_src = 2'b11; trap_valid = 1'b1; trap_vector = 32'h80000003;
        applyStimulus(1'b1, 32'h80000000, 1'b1, 1'b0, 32'h2002, 1'b0, 32'h0);

        // Trap beats a misaligned taken branch in the same cycle.
        trap_vector = 32'hFFFFFFFC; ex_valid = 1'b1; pc_src = 2'b10; branch_taken = 1'b1;
        ex_pc = 32'h400; imm = 32'h2;
        applyStimulus(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h2002, 1'b0, 32'h0);

        // Not-taken branch wraps the PC; pc_src=11 is sequential.
        trap_valid = 1'b0; branch_taken = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h2002, 1'b0, 32'h0);
        pc_src = 2'b11;
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h2002, 1'b0, 32'h0);

        // Misaligned JAL into FAULT, then reset (with a competing trap) mid-FAULT.
        pc_src = 2'b01; ex_pc = 32'h10; imm = 32'h1;
        applyStimulus(1'b0, 32'h4, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0);
        ex_valid = 1'b0; pc_src = 2'b11; rst = 1'b1; trap_valid = 1'b1; trap_vector = 32'h500;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0; trap_valid = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        @(posedge clk);
        #2;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised, registered program-counter unit for the RISC-V core fetch stage.
- Owns the architectural fetch PC and advances it sequentially under a fetch handshake.
- Applies JAL, JALR and taken-branch redirects resolved in execute, and accepts trap redirects.
- Adds what the combinational next-PC select lacks:
  - JALR bit-0 clearing.
  - Misaligned-target detection with a fault hold.
  - Flush signalling.
  - Stall support.
  - A boot cycle after reset.

Parameters:
- XLEN, 32: PC/data width in bits.
- RESET_PC, 0: PC value loaded on reset (XLEN bits).
- IALIGN, 4: instruction alignment in bytes. Legal values are 2 (C extension) and 4. This is also the sequential increment.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts fetch_pc this cycle.
- ex_valid  in  1  execute-stage instruction is valid this cycle.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- pc_src  in  2  00 JALR, 01 JAL, 10 branch, 11 sequential/no redirect.
- branch_taken  in  1  branch predicate result; meaningful only when pc_src=10.
- rs1  in  XLEN  JALR base register value.
- imm  in  XLEN  sign-extended immediate (I, J or B form).
- trap_valid  in  1  trap/exception redirect request.
- trap_vector  in  XLEN  trap target address.
- fetch_valid  out  1  fetch_pc is a valid request.
- fetch_pc  out  XLEN  current PC register.
- link_addr  out  XLEN  ex_pc + 4, combinational; rd data for JAL/JALR.
- flush  out  1  registered pulse: younger in-flight instructions must be squashed.
- misaligned  out  1  registered one-cycle pulse: redirect target misaligned.
- bad_addr  out  XLEN  last misaligned target; held until the next misalignment or reset.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=BOOT, flush=0, misaligned=0, bad_addr=0. This applies in any state, including mid-stall and FAULT. Reset overrides all other inputs.
- States:
  - BOOT: fetch_valid=0. Moves unconditionally to RUN on the next edge (one dead cycle).
  - RUN: fetch_valid=1.
  - FAULT: fetch_valid=0. pc frozen. Exits only on trap_valid.
- fetch_pc = pc register at all times. Output is registered; there is no combinational path from inputs.
- Target computation, XLEN-bit modulo 2^XLEN:
  - JALR target = (rs1 + imm) with bit 0 forced to 0.
  - JAL / branch target = ex_pc + imm.
- redirect_req = ex_valid and (pc_src=00 or pc_src=01 or (pc_src=10 and branch_taken)).
- Misaligned when target mod IALIGN != 0:
  - IALIGN=4: check bits [1:0].
  - IALIGN=2: check bit 0 only, which is always 0 for JALR.
- Next-state priority at each edge, highest first:
  1. rst.
  2. trap_valid (any non-reset state): pc = trap_vector with low log2(IALIGN) bits cleared; state = RUN; flush = 1 next cycle.
  3. redirect_req in RUN, target aligned: pc = target; flush = 1 next cycle. Applies regardless of fetch_ready; the current fetch is squashed.
  4. redirect_req in RUN, target misaligned: pc unchanged; state = FAULT; misaligned = 1 next cycle; bad_addr = target; flush = 1 next cycle.
  5. RUN and fetch_ready: pc = pc + IALIGN, wrapping to 0 past 2^XLEN - IALIGN.
  6. Otherwise (stall, BOOT, FAULT): pc holds.
- Redirect and trap latency: target visible on fetch_pc exactly one cycle after the request edge.
- flush and misaligned deassert the cycle after the pulse unless re-triggered.
- redirect_req while in BOOT or FAULT: ignored; no flush.
- Simultaneous trap_valid and redirect_req: trap wins; redirect discarded; misaligned is not raised even if the redirect target was misaligned.
- pc_src=10 with branch_taken=0, or pc_src=11: treated as no redirect; normal sequential/stall behaviour.
- link_addr is computed regardless of ex_valid.
- Width: all adds truncate to XLEN; no carry out.

Test Plan:
- Reset and boot: assert rst 2 cycles, release with fetch_ready=1 -> fetch_valid=0 for the first cycle; then fetch_pc = 0x0, 0x4, 0x8 on successive cycles. With IALIGN=2: 0x0, 0x2, 0x4.
- Stall plus redirect: pc=0x100, fetch_ready=0, JAL with ex_pc=0x0F8, imm=0x40 -> next cycle fetch_pc=0x138, flush=1; pc holds at 0x138 while fetch_ready=0.
- JALR bit-0 clear: rs1=0x2001, imm=0x4 -> fetch_pc=0x2004, misaligned=0. Then rs1=0x2002, imm=0 (IALIGN=4) -> misaligned=1 for 1 cycle, bad_addr=0x2002, fetch_valid=0, pc frozen.
- FAULT exit and priority: in FAULT, trap_valid=1, trap_vector=0x80000003 -> fetch_pc=0x80000000, state RUN, flush=1. Trap plus taken branch in the same cycle -> trap target wins.
- Branch not taken and wrap: pc_src=10, branch_taken=0 at pc=0xFFFFFFFC, fetch_ready=1 -> fetch_pc=0x0, flush=0.
- Reset mid-FAULT: rst during FAULT -> pc=RESET_PC, misaligned=0, bad_addr=0, one BOOT cycle, then RUN.
